alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Arbitrates a single shared 32-bit ALU between two requesters, the main execute path (port 0) and an auxiliary unit such as a multi-cycle sequencer or an address generator (port 1). Each requester presents operands and a 4-bit ALU opcode with a valid/ready handshake. The block registers the winning request, drives the ALU's BusA/BusB/ALUCtrl inputs, captures BusW/Zero, and returns the result on the winner's response channel. One transaction is outstanding at a time.

## Interface
Parameters:
- DATA_W, 32: operand and result width; must match the ALU bus width.
- FAIR, 1: 1 selects round-robin arbitration, 0 selects fixed priority with port 0 always winning.

Ports:
- CLK  input  1  the only clock. All state updates on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- ReqValid0 / ReqValid1  input  1  request present on port 0 / 1.
- ReqReady0 / ReqReady1  output  1  request accepted this cycle. Combinational.
- ReqA0, ReqB0, ReqA1, ReqB1  input  DATA_W  operands for each port.
- ReqCtrl0, ReqCtrl1  input  4  ALU opcode for each port.
- RspValid0 / RspValid1  output  1  result available for port 0 / 1.
- RspReady0 / RspReady1  input  1  requester takes the result.
- RspData  output  DATA_W  result. Shared by both ports, qualified by RspValidN.
- RspZero  output  1  captured ALU Zero flag.
- ALUBusA, ALUBusB  output  DATA_W  to the ALU BusA and BusB inputs. Registered.
- ALUCtrl  output  4  to the ALU ALUCtrl input. Registered.
- ALUBusW  input  DATA_W  from the ALU result.
- ALUZero  input  1  from the ALU Zero output.

## Operation
- The FSM has three states:
  - IDLE: waiting for a request.
  - EXEC: the ALU is evaluating the latched operands.
  - RESP: holding the result until the requester takes it.
- Grant, evaluated only in IDLE:
  - If exactly one ReqValid is high, that port wins.
  - If both are high and FAIR=1, the port named by the priority pointer `prio` wins.
  - If both are high and FAIR=0, port 0 wins.
- ReqReadyN = (state==IDLE) && grantN. A request is accepted when ReqValidN && ReqReadyN.
- On acceptance:
  - ReqAN, ReqBN and ReqCtrlN are latched into ALUBusA, ALUBusB and ALUCtrl.
  - The winner index is latched into `owner`.
  - The FSM moves to EXEC.
- EXEC lasts one cycle. At its end, ALUBusW is latched into RspData, ALUZero into RspZero, and the FSM moves to RESP.
- RESP:
  - RspValid[owner]=1 and the other RspValid=0.
  - RspData and RspZero are held stable until RspReady[owner]=1.
  - On that handshake the FSM returns to IDLE; with FAIR=1, `prio` is set to ~owner.
  - RspReady on the non-owner port is ignored.
- ALUBusA, ALUBusB and ALUCtrl hold their last values in RESP and IDLE; they do not return to zero.
- Opcodes are forwarded unmodified. Undefined codes (0101, 1111) produce whatever the ALU gives (0, Zero=1), with no error flag.
- A requester may hold ReqValid high while the block is busy; its request is simply not accepted until the next IDLE cycle.
- A request must not be withdrawn before acceptance; doing so is a requester protocol violation and is not checked.

## Timing
- Reset values: state=IDLE, prio=0, owner=0, ALUBusA=0, ALUBusB=0, ALUCtrl=4'b0000, RspData=0, RspZero=0.
- Output values during reset: both RspValid=0, both ReqReady=0.
- Latency: request accepted at cycle T → EXEC at T+1 → RspValid high at T+2.
- Throughput: with RspReady tied high, the block completes one operation per 3 cycles. The next acceptance happens at T+3 at the earliest.
- Simultaneous requests: only one port gets ReqReady in a given cycle; the loser is served in the next IDLE.
- With FAIR=1 and both ports valid continuously, grants strictly alternate, starting with port 0 after reset.
- RspReady low in RESP stalls the block indefinitely. No new request is accepted while stalled.
- Reset asserted in EXEC or RESP aborts the transaction: no response is issued and the result is discarded. Reset wins over any handshake in the same cycle.
- ALU path: ALUBusA/B/Ctrl are driven from flops one full cycle before RspData is captured, so the combinational ALU gets one full cycle to settle.

## Test plan
- Reset → ReqReady0/1=0 and RspValid0/1=0 during reset; after release, ALUCtrl=0, RspData=0 and prio=0.
- Single request on port 0, ADD (0010), A=5, B=7 → ReqReady0 for 1 cycle; RspValid0 exactly 2 cycles later with RspData=12, RspZero=0; RspValid1 stays 0.
- Port 1 SUB (0110), A=6, B=6 with RspReady1 held low for 4 cycles → RspValid1 stays high with RspData=0 and RspZero=1 throughout; no acceptance on either port until the handshake.
- Both ports continuously valid, FAIR=1: port 0 ADD 1+1, port 1 LUI (1110) A=0, B=0x1234 → grants alternate 0,1,0,1; port 1 result 0x12340000; one completion per 3 cycles.
- Same stimulus with FAIR=0 → port 0 wins every arbitration; port 1 is never granted while port 0 stays valid.
- Reset asserted during EXEC of a port 0 SLT (0111), A=0xFFFFFFFF, B=1 → no RspValid0 is issued; after reset the same request replayed returns RspData=1.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters.
// One transaction is in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
module alu_share_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter bit          FAIR   = 1'b1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              ReqValid0,
  input  logic              ReqValid1,
  output logic              ReqReady0,
  output logic              ReqReady1,
  input  logic [DATA_W-1:0] ReqA0,
  input  logic [DATA_W-1:0] ReqB0,
  input  logic [DATA_W-1:0] ReqA1,
  input  logic [DATA_W-1:0] ReqB1,
  input  logic [3:0]        ReqCtrl0,
  input  logic [3:0]        ReqCtrl1,
  output logic              RspValid0,
  output logic              RspValid1,
  input  logic              RspReady0,
  input  logic              RspReady1,
  output logic [DATA_W-1:0] RspData,
  output logic              RspZero,
  output logic [DATA_W-1:0] ALUBusA,
  output logic [DATA_W-1:0] ALUBusB,
  output logic [3:0]        ALUCtrl,
  input  logic [DATA_W-1:0] ALUBusW,
  input  logic              ALUZero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   prio;
  logic   owner;
  logic   grant0, grant1;
  logic   accept;
  logic   rsp_take;

  // Grant selection; only meaningful in IDLE and suppressed while in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !Reset) begin
      if (ReqValid0 && ReqValid1) begin
        if (FAIR && prio) grant1 = 1'b1;
        else              grant0 = 1'b1;
      end else begin
        grant0 = ReqValid0;
        grant1 = ReqValid1;
      end
    end
  end

  assign ReqReady0 = grant0;
  assign ReqReady1 = grant1;
  assign accept    = (ReqValid0 && grant0) || (ReqValid1 && grant1);
  assign rsp_take  = (state == RESP) && (owner ? RspReady1 : RspReady0);
  assign RspValid0 = (state == RESP) && !owner && !Reset;
  assign RspValid1 = (state == RESP) &&  owner && !Reset;

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)   state_nxt = EXEC;
      EXEC:                  state_nxt = RESP;
      RESP:    if (rsp_take) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Request latch, result capture and round-robin pointer update.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      prio    <= 1'b0;
      owner   <= 1'b0;
      ALUBusA <= '0;
      ALUBusB <= '0;
      ALUCtrl <= '0;
      RspData <= '0;
      RspZero <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        owner   <= grant1;
        ALUBusA <= grant1 ? ReqA1    : ReqA0;
        ALUBusB <= grant1 ? ReqB1    : ReqB0;
        ALUCtrl <= grant1 ? ReqCtrl1 : ReqCtrl0;
      end
      if (state == EXEC) begin
        RspData <= ALUBusW;
        RspZero <= ALUZero;
      end
      if (rsp_take && FAIR) prio <= ~owner;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance
// share all requester inputs; each drives its own behavioural ALU.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst;
  logic        req_valid0, req_valid1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]  req_ctrl0, req_ctrl1;
  logic        rsp_ready0, rsp_ready1;

  logic [1:0]  rdy0, rdy1, rv0, rv1, rz, zero;
  logic [31:0] rdata [2];
  logic [31:0] busa  [2];
  logic [31:0] busb  [2];
  logic [3:0]  ctrl  [2];
  logic [31:0] busw  [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        port;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp_d;
    logic        exp_z;
  } vec_t;

  vec_t vecs [7];

  // Behavioural ALU: AND, OR, ADD, SUB, SLT, LUI; anything else yields 0.
  function automatic logic [32:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] c);
    logic [31:0] w;
    case (c)
      4'b0000: w = a & b;
      4'b0001: w = a | b;
      4'b0010: w = a + b;
      4'b0110: w = a - b;
      4'b0111: w = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1110: w = {b[15:0], 16'h0000};
      default: w = '0;
    endcase
    return {(w == 32'd0), w};
  endfunction

  assign {zero[0], busw[0]} = alu(busa[0], busb[0], ctrl[0]);
  assign {zero[1], busw[1]} = alu(busa[1], busb[1], ctrl[1]);

  alu_share_arbiter #(.DATA_W(32), .FAIR(1'b1)) dut_rr (
    .CLK(clk), .Reset(rst),
    .ReqValid0(req_valid0), .ReqValid1(req_valid1),
    .ReqReady0(rdy0[0]), .ReqReady1(rdy1[0]),
    .ReqA0(req_a0), .ReqB0(req_b0), .ReqA1(req_a1), .ReqB1(req_b1),
    .ReqCtrl0(req_ctrl0), .ReqCtrl1(req_ctrl1),
    .RspValid0(rv0[0]), .RspValid1(rv1[0]),
    .RspReady0(rsp_ready0), .RspReady1(rsp_ready1),
    .RspData(rdata[0]), .RspZero(rz[0]),
    .ALUBusA(busa[0]), .ALUBusB(busb[0]), .ALUCtrl(ctrl[0]),
    .ALUBusW(busw[0]), .ALUZero(zero[0])
  );

  alu_share_arbiter #(.DATA_W(32), .FAIR(1'b0)) dut_fp (
    .CLK(clk), .Reset(rst),
    .ReqValid0(req_valid0), .ReqValid1(req_valid1),
    .ReqReady0(rdy0[1]), .ReqReady1(rdy1[1]),
    .ReqA0(req_a0), .ReqB0(req_b0), .ReqA1(req_a1), .ReqB1(req_b1),
    .ReqCtrl0(req_ctrl0), .ReqCtrl1(req_ctrl1),
    .RspValid0(rv0[1]), .RspValid1(rv1[1]),
    .RspReady0(rsp_ready0), .RspReady1(rsp_ready1),
    .RspData(rdata[1]), .RspZero(rz[1]),
    .ALUBusA(busa[1]), .ALUBusB(busb[1]), .ALUCtrl(ctrl[1]),
    .ALUBusW(busw[1]), .ALUZero(zero[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut %0d): got %h expected %h", name, inst, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated request from IDLE; returns one cycle after the response handshake.
  task automatic run_vec(input vec_t v);
    if (v.port) begin
      req_valid1 = 1'b1; req_a1 = v.a; req_b1 = v.b; req_ctrl1 = v.op;
    end else begin
      req_valid0 = 1'b1; req_a0 = v.a; req_b0 = v.b; req_ctrl0 = v.op;
    end
    rsp_ready0 = 1'b1;
    rsp_ready1 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("accept_rdy0", i, 32'(rdy0[i]), 32'(!v.port));
      check("accept_rdy1", i, 32'(rdy1[i]), 32'(v.port));
      check("accept_rv",   i, 32'({rv1[i], rv0[i]}), 32'd0);
    end
    step();
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("exec_busa", i, busa[i], v.a);
      check("exec_busb", i, busb[i], v.b);
      check("exec_ctrl", i, 32'(ctrl[i]), 32'(v.op));
      check("exec_rv",   i, 32'({rv1[i], rv0[i]}), 32'd0);
      check("exec_rdy",  i, 32'({rdy1[i], rdy0[i]}), 32'd0);
    end
    step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("resp_rv0",  i, 32'(rv0[i]), 32'(!v.port));
      check("resp_rv1",  i, 32'(rv1[i]), 32'(v.port));
      check("resp_data", i, rdata[i], v.exp_d);
      check("resp_zero", i, 32'(rz[i]), 32'(v.exp_z));
    end
    step();
  endtask

  initial begin
    vecs[0] = '{port: 1'b0, a: 32'd5,          b: 32'd7,      op: 4'b0010, exp_d: 32'd12,         exp_z: 1'b0};
    vecs[1] = '{port: 1'b1, a: 32'h0000_00F0,  b: 32'h0F,     op: 4'b0001, exp_d: 32'h0000_00FF,  exp_z: 1'b0};
    vecs[2] = '{port: 1'b0, a: 32'h0000_00F0,  b: 32'h0F,     op: 4'b0000, exp_d: 32'd0,          exp_z: 1'b1};
    vecs[3] = '{port: 1'b1, a: 32'd3,          b: 32'd5,      op: 4'b0111, exp_d: 32'd1,          exp_z: 1'b0};
    vecs[4] = '{port: 1'b0, a: 32'd0,          b: 32'hABCD,   op: 4'b1110, exp_d: 32'hABCD_0000,  exp_z: 1'b0};
    vecs[5] = '{port: 1'b1, a: 32'd9,          b: 32'd4,      op: 4'b0101, exp_d: 32'd0,          exp_z: 1'b1};
    vecs[6] = '{port: 1'b0, a: 32'd10,         b: 32'd3,      op: 4'b0110, exp_d: 32'd7,          exp_z: 1'b0};

    rst = 1'b1;
    req_valid0 = 1'b1; req_valid1 = 1'b1;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    req_ctrl0 = 4'b0010; req_ctrl1 = 4'b0010;
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;

    // Reset: requests pending but nothing may be accepted or returned.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check("reset_rdy", i, 32'({rdy1[i], rdy0[i]}), 32'd0);
        check("reset_rv",  i, 32'({rv1[i], rv0[i]}), 32'd0);
      end
    end
    step();
    rst = 1'b0;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("post_reset_ctrl", i, 32'(ctrl[i]), 32'd0);
      check("post_reset_busa", i, busa[i], 32'd0);
      check("post_reset_data", i, rdata[i], 32'd0);
      check("post_reset_zero", i, 32'(rz[i]), 32'd0);
    end
    step();

    // Isolated single-port transactions.
    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // Port 1 SUB 6-6 with a 4-cycle response stall; port 0 waits meanwhile.
    req_valid1 = 1'b1; req_a1 = 32'd6; req_b1 = 32'd6; req_ctrl1 = 4'b0110;
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("stall_accept", i, 32'(rdy1[i]), 32'd1);
    step();
    req_valid1 = 1'b0;
    req_valid0 = 1'b1; req_a0 = 32'd2; req_b0 = 32'd3; req_ctrl0 = 4'b0010;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("stall_exec_rdy", i, 32'({rdy1[i], rdy0[i]}), 32'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check("stall_rv1",  i, 32'(rv1[i]), 32'd1);
        check("stall_rv0",  i, 32'(rv0[i]), 32'd0);
        check("stall_data", i, rdata[i], 32'd0);
        check("stall_zero", i, 32'(rz[i]), 32'd1);
        check("stall_rdy",  i, 32'({rdy1[i], rdy0[i]}), 32'd0);
      end
    end
    step();
    rsp_ready1 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("stall_release_rv1", i, 32'(rv1[i]), 32'd1);
    step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("waiter_rdy0", i, 32'(rdy0[i]), 32'd1);
      check("waiter_rv1",  i, 32'(rv1[i]), 32'd0);
    end
    step();
    req_valid0 = 1'b0;
    step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("waiter_rv0",  i, 32'(rv0[i]), 32'd1);
      check("waiter_data", i, rdata[i], 32'd5);
    end
    step();

    // Continuous contention; reset first so the round-robin pointer starts at port 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid0 = 1'b1; req_a0 = 32'd1; req_b0 = 32'd1;      req_ctrl0 = 4'b0010;
    req_valid1 = 1'b1; req_a1 = 32'd0; req_b1 = 32'h1234;   req_ctrl1 = 4'b1110;
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        logic own;
        own = (i == 0) ? 1'((c / 3) % 2) : 1'b0;
        case (c % 3)
          0: begin
            check("arb_rdy0", i, 32'(rdy0[i]), 32'(!own));
            check("arb_rdy1", i, 32'(rdy1[i]), 32'(own));
          end
          1: begin
            check("arb_exec_ctrl", i, 32'(ctrl[i]), own ? 32'hE : 32'h2);
            check("arb_exec_rdy",  i, 32'({rdy1[i], rdy0[i]}), 32'd0);
          end
          default: begin
            check("arb_rv0",  i, 32'(rv0[i]), 32'(!own));
            check("arb_rv1",  i, 32'(rv1[i]), 32'(own));
            check("arb_data", i, rdata[i], own ? 32'h1234_0000 : 32'd2);
          end
        endcase
      end
      step();
    end
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;

    // Reset during EXEC of a port 0 SLT discards the result.
    req_valid0 = 1'b1; req_a0 = 32'hFFFF_FFFF; req_b0 = 32'd1; req_ctrl0 = 4'b0111;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("abort_accept", i, 32'(rdy0[i]), 32'd1);
    step();
    req_valid0 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("abort_rv_in_reset", i, 32'({rv1[i], rv0[i]}), 32'd0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check("abort_no_rsp", i, 32'({rv1[i], rv0[i]}), 32'd0);
        check("abort_data",   i, rdata[i], 32'd0);
        check("abort_ctrl",   i, 32'(ctrl[i]), 32'd0);
      end
      step();
    end
    run_vec('{port: 1'b0, a: 32'hFFFF_FFFF, b: 32'd1, op: 4'b0111, exp_d: 32'd1, exp_z: 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
